// File: rtl/cpu_bus_master_if.sv
// cpu_bus_master_if: host request/response handshake plus the 6502-style cart
// bus, bundled for cpu_bus_master.
//   master modport : the bus initiator (drives req_ready, resp_*, and the CPU bus)
//   slave modport  : host + cart side (drives req_*, samples the bus, supplies cpu_data_in)
interface cpu_bus_master_if;
  // host side
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  // cart connector side
  logic        m2;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic        romsel_n;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, cpu_data_in,
    output req_ready, resp_valid, resp_rdata,
           m2, cpu_rw, cpu_addr, cpu_data_out, cpu_data_oe, romsel_n
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, cpu_data_in,
    input  req_ready, resp_valid, resp_rdata,
           m2, cpu_rw, cpu_addr, cpu_data_out, cpu_data_oe, romsel_n
  );
endinterface

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: NES CPU-side bus initiator. It runs a free-running M2 made of
// T_LO low clks followed by T_HI high clks. Each host request becomes one bus
// cycle. When no request is pending, the cycle is a dummy read of IDLE_ADDR.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : cpu_bus_master_if.master, which carries the host req/resp
//           handshake and the cart bus (m2, cpu_rw, cpu_addr, data, romsel_n)
// Every bus output is registered. The value loaded on an edge is the value for
// the phase that edge enters (ph_nxt).
module cpu_bus_master #(
  parameter int          T_LO      = 3,
  parameter int          T_HI      = 3,
  parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  cpu_bus_master_if.master bus
);

  localparam int CYC = T_LO + T_HI;
  localparam int PW  = $clog2(CYC);
  localparam logic [PW-1:0] PH_LAST = PW'(CYC - 1);
  localparam logic [PW-1:0] PH_HI   = PW'(T_LO);

  logic [PW-1:0] ph, ph_nxt;
  logic          active;   // current bus cycle belongs to a host request
  logic          accept;
  logic          m2_nxt;

  assign ph_nxt        = (ph == PH_LAST) ? '0 : ph + 1'b1;
  assign m2_nxt        = (ph_nxt >= PH_HI);
  assign bus.req_ready = (ph == '0) & ~reset;
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph               <= '0;
      active           <= 1'b0;
      bus.m2           <= 1'b0;
      bus.cpu_rw       <= 1'b1;
      bus.cpu_addr     <= IDLE_ADDR;
      bus.cpu_data_out <= 8'h00;
      bus.cpu_data_oe  <= 1'b0;
      bus.romsel_n     <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= 8'h00;
    end else begin
      ph     <= ph_nxt;
      bus.m2 <= m2_nxt;
      // cpu_addr was settled at least one clk before M2 rises (T_LO >= 2),
      // so the current register value is the one M2-high will show.
      bus.romsel_n <= ~(m2_nxt & bus.cpu_addr[15]);

      // The edge that ends the last M2-high clk closes the bus cycle. The
      // response then appears during the following ph=0.
      bus.resp_valid <= (ph == PH_LAST) & active;
      if ((ph == PH_LAST) && active && bus.cpu_rw)
        bus.resp_rdata <= bus.cpu_data_in;

      // Leaving ph=0 launches the next cycle. Address, rw and oe stay stable
      // through ph=0 so a mapper that latches on M2 falling gets one clk of hold.
      if (ph == '0) begin
        active <= accept;
        if (accept) begin
          bus.cpu_rw       <= bus.req_rw;
          bus.cpu_addr     <= bus.req_addr;
          bus.cpu_data_oe  <= ~bus.req_rw;
          if (!bus.req_rw)
            bus.cpu_data_out <= bus.req_wdata;
        end else begin
          bus.cpu_rw      <= 1'b1;
          bus.cpu_addr    <= IDLE_ADDR;
          bus.cpu_data_oe <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
module tb_cpu_bus_master;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_bus_master_if bus();

  cpu_bus_master #(.T_LO(3), .T_HI(3), .IDLE_ADDR(16'h0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic [7:0]  exp_rdata;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Present a request and wait (bounded) for the ph=0 that accepts it.
  task automatic issue(input logic rw, input logic [15:0] a, input logic [7:0] wd);
    bus.req_rw    = rw;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    chk("issue_ready", 32'(bus.req_ready), 32'd1);
  endtask

  // This task is entered on the negedge of the accepting ph=0. It follows the
  // next six clks (ph 1..5, then ph 0) and checks every bus output against
  // the cycle it expects.
  task automatic watch(input string nm, input logic rw, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_resp);
    int bad_m2 = 0, bad_bus = 0, bad_oe = 0, bad_rs = 0, bad_rv = 0;
    logic exp_m2;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      exp_m2 = (k >= 3 && k <= 5);
      if (bus.m2 !== exp_m2) bad_m2++;
      if (bus.cpu_addr !== a || bus.cpu_rw !== rw) bad_bus++;
      if (bus.cpu_data_oe !== ~rw || (!rw && bus.cpu_data_out !== wd)) bad_oe++;
      if (bus.romsel_n !== ~(exp_m2 & a[15])) bad_rs++;
      if (bus.resp_valid !== (exp_resp && k == 6)) bad_rv++;
    end
    chk({nm, "_m2"},     32'(bad_m2),  32'd0);
    chk({nm, "_addrrw"}, 32'(bad_bus), 32'd0);
    chk({nm, "_oe"},     32'(bad_oe),  32'd0);
    chk({nm, "_romsel"}, 32'(bad_rs),  32'd0);
    chk({nm, "_resp"},   32'(bad_rv),  32'd0);
    chk({nm, "_rdata"},  32'(bus.resp_rdata), 32'(exp_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hi_cnt, bad_pat, bad_bus, rv_cnt;
    vecs[0] = '{rw:1'b0, addr:16'h5100, wdata:8'h0A, din:8'h00, exp_rdata:8'h00};
    vecs[1] = '{rw:1'b1, addr:16'h8000, wdata:8'h00, din:8'h5A, exp_rdata:8'h5A};
    vecs[2] = '{rw:1'b1, addr:16'h1234, wdata:8'h00, din:8'hC3, exp_rdata:8'hC3};
    vecs[3] = '{rw:1'b0, addr:16'hFFFF, wdata:8'hFF, din:8'h11, exp_rdata:8'hC3};

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_rw = 1'b1; bus.req_addr = 16'h0; bus.req_wdata = 8'h0;
    bus.cpu_data_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_m2",     32'(bus.m2),           32'd0);
    chk("rst_rw",     32'(bus.cpu_rw),       32'd1);
    chk("rst_addr",   32'(bus.cpu_addr),     32'h0000);
    chk("rst_dout",   32'(bus.cpu_data_out), 32'd0);
    chk("rst_oe",     32'(bus.cpu_data_oe),  32'd0);
    chk("rst_romsel", 32'(bus.romsel_n),     32'd1);
    chk("rst_rv",     32'(bus.resp_valid),   32'd0);
    chk("rst_rdata",  32'(bus.resp_rdata),   32'd0);
    chk("rst_ready",  32'(bus.req_ready),    32'd0);
    reset = 1'b0;
    #1 chk("rel_ready", 32'(bus.req_ready), 32'd1);

    // single transactions from the table
    for (int i = 0; i < 4; i++) begin
      bus.cpu_data_in = vecs[i].din;
      issue(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      watch($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
            vecs[i].exp_rdata, 1'b1);
    end

    // back-to-back writes: the second is accepted in the first one's response ph=0
    issue(1'b0, 16'h5000, 8'h03);
    watch("b2b_a", 1'b0, 16'h5000, 8'h03, 8'hC3, 1'b1);
    chk("b2b_ready_on_resp", 32'(bus.req_ready & bus.resp_valid), 32'd1);
    issue(1'b0, 16'h5300, 8'h05);
    watch("b2b_b", 1'b0, 16'h5300, 8'h05, 8'hC3, 1'b1);

    // four idle bus cycles
    bus.cpu_data_in = 8'hEE;
    hi_cnt = 0; bad_pat = 0; bad_bus = 0; rv_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (bus.m2) hi_cnt++;
      if (bus.m2 !== ((k % 6) >= 3)) bad_pat++;
      if (bus.cpu_addr !== 16'h0000 || bus.cpu_rw !== 1'b1 || bus.cpu_data_oe !== 1'b0
          || bus.romsel_n !== 1'b1) bad_bus++;
      if (bus.resp_valid) rv_cnt++;
    end
    chk("idle_m2_high", 32'(hi_cnt),  32'd12);
    chk("idle_m2_pat",  32'(bad_pat), 32'd0);
    chk("idle_bus",     32'(bad_bus), 32'd0);
    chk("idle_resp",    32'(rv_cnt),  32'd0);
    chk("idle_rdata",   32'(bus.resp_rdata), 32'hC3);

    // request raised at ph=3 waits for the next ph=0
    repeat (3) @(negedge clk);
    bus.cpu_data_in = 8'h3C;
    bus.req_rw = 1'b1; bus.req_addr = 16'h9000; bus.req_wdata = 8'h00; bus.req_valid = 1'b1;
    chk("late_ready_ph3", 32'(bus.req_ready), 32'd0);
    @(negedge clk); chk("late_ready_ph4", 32'(bus.req_ready), 32'd0);
    @(negedge clk); chk("late_ready_ph5", 32'(bus.req_ready), 32'd0);
    @(negedge clk); chk("late_ready_ph0", 32'(bus.req_ready), 32'd1);
    watch("late", 1'b1, 16'h9000, 8'h00, 8'h3C, 1'b1);

    // reset in the middle of a write (ph=4, M2 high)
    issue(1'b0, 16'h5200, 8'h77);
    repeat (4) @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_m2_before", 32'(bus.m2), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_m2",     32'(bus.m2),          32'd0);
    chk("mid_oe",     32'(bus.cpu_data_oe), 32'd0);
    chk("mid_rw",     32'(bus.cpu_rw),      32'd1);
    chk("mid_romsel", 32'(bus.romsel_n),    32'd1);
    chk("mid_ready",  32'(bus.req_ready),   32'd0);
    @(negedge clk);
    chk("mid_rv", 32'(bus.resp_valid), 32'd0);
    reset = 1'b0;
    watch("post_rst", 1'b1, 16'h0000, 8'h00, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
